tb_fs_port_arbiter: RTL and testbench

Shares the single testbench stdout/filesystem handler port (CSN/WEN/ADDR/WDATA/BE/RDATA) between NB_REQ requesters, e.g. cluster cores and the FC.
- Round-robin arbitration.
- Two lock types keep transactions atomic:
  - Line lock: a stdout line from one requester is not interleaved with another requester's characters.
  - File session lock: all traffic between FOPEN and FCLOSE belongs to one requester.
- Tracks read latency so each read byte from the RW address is returned to the requester that issued it.

---
 rtl/tb_fs_port_arbiter_if.sv | 17 +
 rtl/tb_fs_port_arbiter.sv | 131 +++++++++++++
 tb/tb_tb_fs_port_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/tb_fs_port_arbiter_if.sv
// tb_fs_port_arbiter_if: requester-side bundle of the testbench handler-port arbiter
interface tb_fs_port_arbiter_if #(
    parameter int NB_REQ     = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic [NB_REQ-1:0]              req_i;
    logic [NB_REQ-1:0]              we_i;
    logic [NB_REQ*ADDR_WIDTH-1:0]   addr_i;
    logic [NB_REQ*DATA_WIDTH-1:0]   wdata_i;
    logic [NB_REQ*DATA_WIDTH/8-1:0] be_i;
    logic [NB_REQ-1:0]              gnt_o;
    logic [NB_REQ-1:0]              rvalid_o;
    logic [DATA_WIDTH-1:0]          rdata_o;
    modport master (output req_i, we_i, addr_i, wdata_i, be_i, input gnt_o, rvalid_o, rdata_o);
    modport slave  (input req_i, we_i, addr_i, wdata_i, be_i, output gnt_o, rvalid_o, rdata_o);
endinterface

// File: rtl/tb_fs_port_arbiter.sv
// tb_fs_port_arbiter: round-robin sharing of the stdout/fs handler port with line, file-session and read-return tracking
module tb_fs_port_arbiter #(
    parameter int                    NB_REQ       = 4,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    READ_LATENCY = 2,
    parameter int                    LOCK_TIMEOUT = 1024,
    parameter logic [ADDR_WIDTH-1:0] STDOUT_BASE  = 32'h1A10F000,
    parameter logic [ADDR_WIDTH-1:0] FS_CMD_ADDR  = 32'h1A112000,
    parameter logic [ADDR_WIDTH-1:0] FS_RW_ADDR   = 32'h1A113000
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    tb_fs_port_arbiter_if.slave     bus,
    output logic                    CSN,
    output logic                    WEN,
    output logic [ADDR_WIDTH-1:0]   ADDR,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] BE,
    input  logic [DATA_WIDTH-1:0]   RDATA_i
);
    localparam int IDW = NB_REQ > 1 ? $clog2(NB_REQ) : 1;
    localparam int CW  = LOCK_TIMEOUT > 0 ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam int BW  = DATA_WIDTH / 8;
    localparam logic [1:0] IDLE = 2'd0, LINE_LOCK = 2'd1, FILE_LOCK = 2'd2, RD_WAIT = 2'd3;

    logic [1:0]                       state_q, state_d, ret_q, ret_d;
    logic [IDW-1:0]                   owner_q, owner_d, ptr_q, ptr_d, gid;
    logic [CW-1:0]                    cnt_q, cnt_d;
    logic [READ_LATENCY-1:0]          vld_q, vld_d;
    logic [READ_LATENCY-1:0][IDW-1:0] id_q, id_d;
    logic                             hit, g_we, is_std, is_cmd, eol, rd_done;
    logic [ADDR_WIDTH-1:0]            g_addr;
    logic [DATA_WIDTH-1:0]            g_wdata;
    logic [BW-1:0]                    g_be;

    function automatic logic [IDW-1:0] nxt(input logic [IDW-1:0] r);
        return int'(r) == NB_REQ - 1 ? '0 : IDW'(r + 1'b1);
    endfunction

    always_comb begin
        hit = 1'b0;
        gid = owner_q;
        if (rst_ni) begin
            if (state_q == IDLE) begin
                // scan downward so the requester closest to the pointer wins last
                for (int i = NB_REQ - 1; i >= 0; i--) begin
                    if (bus.req_i[(int'(ptr_q) + i) % NB_REQ]) begin
                        hit = 1'b1;
                        gid = IDW'((int'(ptr_q) + i) % NB_REQ);
                    end
                end
            end else if (state_q != RD_WAIT) begin
                hit = bus.req_i[owner_q];
            end
        end
        g_we    = bus.we_i[gid];
        g_addr  = bus.addr_i[gid*ADDR_WIDTH +: ADDR_WIDTH];
        g_wdata = bus.wdata_i[gid*DATA_WIDTH +: DATA_WIDTH];
        g_be    = bus.be_i[gid*BW +: BW];
        is_std  = g_addr[ADDR_WIDTH-1:12] == STDOUT_BASE[ADDR_WIDTH-1:12];
        is_cmd  = g_addr == FS_CMD_ADDR;
        eol     = g_wdata[7:0] == 8'h0A || g_wdata[7:0] == 8'h00;
        rd_done = rst_ni && vld_q[READ_LATENCY-1];
    end

    always_comb begin
        bus.gnt_o    = hit ? NB_REQ'(1) << gid : '0;
        bus.rvalid_o = rd_done ? NB_REQ'(1) << id_q[READ_LATENCY-1] : '0;
        bus.rdata_o  = rd_done ? RDATA_i : '0;
        CSN          = ~hit;
        WEN          = hit ? ~g_we : 1'b1;
        ADDR         = hit ? g_addr : '0;
        WDATA        = hit ? g_wdata : '0;
        BE           = hit ? g_be : '0;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = hit && state_q == IDLE ? nxt(gid) : ptr_q;
        ret_d   = ret_q;
        cnt_d   = '0;
        vld_d   = {vld_q, hit && !g_we};
        id_d    = {id_q, gid};
        if (hit && g_we) begin
            if (is_cmd && g_wdata == '0) begin
                state_d = FILE_LOCK;
                owner_d = gid;
            end else if (is_cmd && g_wdata == DATA_WIDTH'(1)) begin
                state_d = IDLE;
            end else if (is_std && state_q != FILE_LOCK) begin
                state_d = eol ? IDLE : LINE_LOCK;
                owner_d = gid;
            end
        end else if (hit) begin
            ret_d   = state_q;
            owner_d = gid;
            state_d = RD_WAIT;
        end
        if (LOCK_TIMEOUT != 0 && state_q == LINE_LOCK && !bus.req_i[owner_q]) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CW'(LOCK_TIMEOUT)) begin
                state_d = IDLE;
                ptr_d   = nxt(owner_q);
                cnt_d   = '0;
            end
        end
        if (state_q == RD_WAIT && rd_done) state_d = ret_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ret_q   <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            vld_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            id_q    <= id_d;
        end
    end
endmodule

// File: tb/tb_tb_fs_port_arbiter.sv
// tb_tb_fs_port_arbiter: directed self-checking bench for tb_fs_port_arbiter
module tb_tb_fs_port_arbiter;
    localparam logic [31:0] STD = 32'h1A10F000, CMD = 32'h1A112000, RW = 32'h1A113000;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    int n_vec = 0, n_err = 0;

    tb_fs_port_arbiter_if #(.NB_REQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(64)) a_if ();
    tb_fs_port_arbiter_if #(.NB_REQ(1), .ADDR_WIDTH(32), .DATA_WIDTH(64)) b_if ();
    logic        a_csn, a_wen, b_csn, b_wen;
    logic [31:0] a_addr, b_addr;
    logic [63:0] a_wdata, a_rdata, b_wdata, b_rdata;
    logic [7:0]  a_be, b_be;

    tb_fs_port_arbiter #(.NB_REQ(4), .LOCK_TIMEOUT(8)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(a_if.slave), .CSN(a_csn), .WEN(a_wen),
        .ADDR(a_addr), .WDATA(a_wdata), .BE(a_be), .RDATA_i(a_rdata));
    tb_fs_port_arbiter #(.NB_REQ(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .bus(b_if.slave), .CSN(b_csn), .WEN(b_wen),
        .ADDR(b_addr), .WDATA(b_wdata), .BE(b_be), .RDATA_i(b_rdata));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int r, input logic rq, input logic wr, input logic [31:0] ad, input logic [63:0] wd);
        a_if.req_i[r]          = rq;
        a_if.we_i[r]           = wr;
        a_if.addr_i[r*32 +: 32] = ad;
        a_if.wdata_i[r*64 +: 64] = wd;
        a_if.be_i[r*8 +: 8]     = 8'hFF;
    endtask

    logic [7:0] chars [4] = '{8'h68, 8'h69, 8'h21, 8'h0A};

    initial begin
        rst_n = 1'b0;
        a_if.req_i = '0; a_if.we_i = '0; a_if.addr_i = '0; a_if.wdata_i = '0; a_if.be_i = '0;
        b_if.req_i = '0; b_if.we_i = '0; b_if.addr_i = '0; b_if.wdata_i = '0; b_if.be_i = '0;
        a_rdata = '0;
        b_rdata = '0;
        for (int r = 0; r < 4; r++) drv(r, 1'b1, 1'b1, STD + 32'(r * 4), 64'h0A);
        tick; tick; #2;
        chk("rst_gnt", 64'(a_if.gnt_o), 64'h0);
        chk("rst_rvalid", 64'(a_if.rvalid_o), 64'h0);
        chk("rst_rdata", a_if.rdata_o, 64'h0);
        chk("rst_csn", 64'(a_csn), 64'h1);
        chk("rst_wen", 64'(a_wen), 64'h1);
        chk("rst_addr", 64'(a_addr), 64'h0);
        chk("rst_wdata", a_wdata, 64'h0);
        chk("rst_be", 64'(a_be), 64'h0);
        tick;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("rr_gnt", 64'(a_if.gnt_o), 64'(1) << (k % 4));
            chk("rr_csn", 64'(a_csn), 64'h0);
            chk("rr_addr", 64'(a_addr), 64'(STD + 32'((k % 4) * 4)));
            tick;
        end
        for (int r = 0; r < 4; r++) drv(r, 1'b0, 1'b1, STD, 64'h0A);
        drv(0, 1'b1, 1'b1, STD, 64'h41);
        #2; chk("line_a_gnt", 64'(a_if.gnt_o), 64'h1); chk("line_a_wdata", a_wdata, 64'h41); tick;
        drv(0, 1'b1, 1'b1, STD, 64'h42);
        drv(1, 1'b1, 1'b1, STD + 32'd4, 64'h0A);
        #2; chk("line_b_gnt", 64'(a_if.gnt_o), 64'h1); chk("line_b_wdata", a_wdata, 64'h42); tick;
        drv(0, 1'b1, 1'b1, STD, 64'h0A);
        #2; chk("line_nl_gnt", 64'(a_if.gnt_o), 64'h1); tick;
        drv(0, 1'b0, 1'b1, STD, 64'h0A);
        #2; chk("line_rel_gnt", 64'(a_if.gnt_o), 64'h2); tick;
        drv(1, 1'b0, 1'b1, STD, 64'h0A);
        drv(2, 1'b1, 1'b1, CMD, 64'h0);
        drv(0, 1'b1, 1'b1, STD, 64'h0A);
        #2; chk("fopen_gnt", 64'(a_if.gnt_o), 64'h4); chk("fopen_addr", 64'(a_addr), 64'(CMD)); tick;
        drv(2, 1'b1, 1'b1, RW, 64'h61);
        #2; chk("fwr1_gnt", 64'(a_if.gnt_o), 64'h4); tick;
        drv(2, 1'b1, 1'b1, RW, 64'h62);
        #2; chk("fwr2_gnt", 64'(a_if.gnt_o), 64'h4); tick;
        drv(2, 1'b1, 1'b0, RW, 64'h0);
        #2;
        chk("frd_gnt", 64'(a_if.gnt_o), 64'h4);
        chk("frd_wen", 64'(a_wen), 64'h1);
        chk("frd_addr", 64'(a_addr), 64'(RW));
        tick;
        drv(2, 1'b0, 1'b0, RW, 64'h0);
        a_rdata = 64'h1111;
        #2; chk("rdw_gnt", 64'(a_if.gnt_o), 64'h0); chk("rdw_rvalid", 64'(a_if.rvalid_o), 64'h0); tick;
        a_rdata = 64'hDEADBEEF00000042;
        #2;
        chk("rd_rvalid", 64'(a_if.rvalid_o), 64'h4);
        chk("rd_rdata", a_if.rdata_o, 64'hDEADBEEF00000042);
        chk("rd_gnt", 64'(a_if.gnt_o), 64'h0);
        tick;
        a_rdata = '0;
        #2; chk("flock_gnt", 64'(a_if.gnt_o), 64'h0); chk("rd_once", 64'(a_if.rvalid_o), 64'h0); tick;
        drv(2, 1'b1, 1'b1, CMD, 64'h1);
        #2; chk("fclose_gnt", 64'(a_if.gnt_o), 64'h4); tick;
        drv(2, 1'b0, 1'b1, CMD, 64'h1);
        #2; chk("post_fclose_gnt", 64'(a_if.gnt_o), 64'h1); tick;
        drv(0, 1'b0, 1'b1, STD, 64'h0A);
        drv(1, 1'b1, 1'b1, STD, 64'h78);
        drv(3, 1'b1, 1'b1, STD + 32'd12, 64'h0A);
        #2; chk("to_lock_gnt", 64'(a_if.gnt_o), 64'h2); tick;
        drv(1, 1'b0, 1'b1, STD, 64'h78);
        for (int k = 0; k < 8; k++) begin
            #2; chk("to_hold_gnt", 64'(a_if.gnt_o), 64'h0); tick;
        end
        #2; chk("to_release_gnt", 64'(a_if.gnt_o), 64'h8); tick;
        drv(3, 1'b0, 1'b1, STD, 64'h0A);
        drv(0, 1'b1, 1'b0, RW, 64'h0);
        #2; chk("rstrd_gnt", 64'(a_if.gnt_o), 64'h1); chk("rstrd_wen", 64'(a_wen), 64'h1); tick;
        drv(0, 1'b0, 1'b0, RW, 64'h0);
        rst_n = 1'b0;
        a_rdata = 64'h55;
        #2; chk("rstrd_rvalid0", 64'(a_if.rvalid_o), 64'h0); chk("rstrd_gnt0", 64'(a_if.gnt_o), 64'h0); tick;
        rst_n = 1'b1;
        #2;
        chk("rstrd_rvalid1", 64'(a_if.rvalid_o), 64'h0);
        chk("rstrd_rdata1", a_if.rdata_o, 64'h0);
        chk("rstrd_csn1", 64'(a_csn), 64'h1);
        tick;
        #2; chk("rstrd_rvalid2", 64'(a_if.rvalid_o), 64'h0); tick;
        drv(0, 1'b1, 1'b1, STD, 64'h0A);
        drv(1, 1'b1, 1'b1, STD + 32'd4, 64'h0A);
        #2; chk("post_rst_ptr", 64'(a_if.gnt_o), 64'h1); tick;
        drv(0, 1'b0, 1'b1, STD, 64'h0A);
        drv(1, 1'b0, 1'b1, STD, 64'h0A);
        b_if.req_i = 1'b1;
        b_if.we_i = 1'b1;
        b_if.addr_i = STD;
        b_if.be_i = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            b_if.wdata_i = 64'(chars[k]);
            #2;
            chk("single_gnt", 64'(b_if.gnt_o), 64'h1);
            chk("single_csn", 64'(b_csn), 64'h0);
            chk("single_wdata", b_wdata, 64'(chars[k]));
            tick;
        end
        b_if.req_i = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
